// File: rtl/can_err_frm_ctrl_if.sv
// Signal bundle between the CAN-XL receive checkers and the error-frame sequencer.
// The sequencer uses the slave modport; the checker side uses the master modport.
interface can_err_frm_ctrl_if;
    logic       bit_tick;
    logic       serial_in;
    logic       bit_err;
    logic       stf_err;
    logic       crc_err;
    logic       frm_err;
    logic       ack_err;
    logic       err_psv;
    logic       bus_off;
    logic       act_err_frm_tx;
    logic       psv_err_frm_tx;
    logic       err_tx_bit;
    logic [2:0] err_code;
    logic       err_evt;
    logic       err_frm_done;

    modport master (
        output bit_tick, serial_in, bit_err, stf_err, crc_err, frm_err, ack_err,
        output err_psv, bus_off,
        input  act_err_frm_tx, psv_err_frm_tx, err_tx_bit, err_code, err_evt, err_frm_done
    );

    modport slave (
        input  bit_tick, serial_in, bit_err, stf_err, crc_err, frm_err, ack_err,
        input  err_psv, bus_off,
        output act_err_frm_tx, psv_err_frm_tx, err_tx_bit, err_code, err_evt, err_frm_done
    );
endinterface

// File: rtl/can_err_frm_ctrl.sv
// CAN-XL error-frame sequencer: merges checker flags, then paces an active or passive
// error flag, delimiter and intermission on the bit-time strobe.
module can_err_frm_ctrl #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int IFS_LEN   = 3,
    parameter int DOM_LIMIT = 14
) (
    input logic               clk,
    input logic               g_rst_n,
    can_err_frm_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, FLAG, FLAG_WAIT, DELIM, IFS} state_t;

    localparam logic [3:0] FLAG_LAST = 4'(FLAG_LEN - 1);
    localparam logic [3:0] FLAG_END  = 4'(FLAG_LEN);
    localparam logic [3:0] DELIM_END = 4'(DELIM_LEN);
    localparam logic [3:0] IFS_LAST  = 4'(IFS_LEN - 1);
    localparam logic [4:0] DOM_LIM   = 5'(DOM_LIMIT);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [4:0] dom_cnt, dom_cnt_nx;
    logic       act, act_nx;
    logic       psv, psv_nx;
    logic       evt, evt_nx;
    logic       done, done_nx;
    logic       prev_bit, prev_bit_nx;
    logic [2:0] code, code_nx;
    logic       any_err;
    logic [2:0] new_code;
    logic [3:0] psv_step;
    logic [4:0] dom_inc;
    logic [2:0] dom_phase;

    always_ff @(posedge clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dom_cnt  <= '0;
            act      <= 1'b0;
            psv      <= 1'b0;
            evt      <= 1'b0;
            done     <= 1'b0;
            prev_bit <= 1'b1;
            code     <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            dom_cnt  <= dom_cnt_nx;
            act      <= act_nx;
            psv      <= psv_nx;
            evt      <= evt_nx;
            done     <= done_nx;
            prev_bit <= prev_bit_nx;
            code     <= code_nx;
        end
    end

    // Cause priority when several checkers fire together: bit > stuff > crc > form > ack.
    always_comb begin
        any_err  = bus.bit_err | bus.stf_err | bus.crc_err | bus.frm_err | bus.ack_err;
        new_code = 3'd0;
        if (bus.bit_err)      new_code = 3'd1;
        else if (bus.stf_err) new_code = 3'd2;
        else if (bus.crc_err) new_code = 3'd3;
        else if (bus.frm_err) new_code = 3'd4;
        else if (bus.ack_err) new_code = 3'd5;
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        dom_cnt_nx  = dom_cnt;
        act_nx      = act;
        psv_nx      = psv;
        code_nx     = code;
        evt_nx      = 1'b0;
        done_nx     = 1'b0;
        prev_bit_nx = prev_bit;
        psv_step    = (bus.serial_in != prev_bit) ? 4'd1 : cnt + 4'd1;
        dom_inc     = dom_cnt + 5'd1;
        dom_phase   = dom_inc[2:0] - DOM_LIM[2:0];

        if (bus.bus_off) begin
            state_nx   = IDLE;
            act_nx     = 1'b0;
            psv_nx     = 1'b0;
            cnt_nx     = '0;
            dom_cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_err) begin
                        code_nx  = new_code;
                        evt_nx   = 1'b1;
                        state_nx = FLAG;
                        cnt_nx   = '0;
                        act_nx   = ~bus.err_psv;
                        psv_nx   = bus.err_psv;
                    end
                end
                FLAG: begin
                    // Reading recessive while driving dominant restarts the flag.
                    if (act && bus.bit_err) begin
                        evt_nx  = 1'b1;
                        code_nx = 3'd1;
                        cnt_nx  = '0;
                    end else if (bus.bit_tick) begin
                        prev_bit_nx = bus.serial_in;
                        if (act) begin
                            if (cnt == FLAG_LAST) begin
                                state_nx   = FLAG_WAIT;
                                dom_cnt_nx = '0;
                            end else begin
                                cnt_nx = cnt + 4'd1;
                            end
                        end else if (psv_step == FLAG_END) begin
                            state_nx   = FLAG_WAIT;
                            dom_cnt_nx = '0;
                        end else begin
                            cnt_nx = psv_step;
                        end
                    end
                end
                FLAG_WAIT: begin
                    if (bus.bit_tick) begin
                        if (bus.serial_in) begin
                            state_nx = DELIM;
                            cnt_nx   = 4'd1;
                        end else begin
                            dom_cnt_nx = dom_inc;
                            if (dom_inc >= DOM_LIM && dom_phase == 3'd0)
                                evt_nx = 1'b1;
                        end
                    end
                end
                DELIM: begin
                    if (bus.bit_tick) begin
                        if (!bus.serial_in) begin
                            code_nx  = 3'd4;
                            evt_nx   = 1'b1;
                            state_nx = FLAG;
                            cnt_nx   = '0;
                        end else if (cnt + 4'd1 == DELIM_END) begin
                            state_nx = IFS;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 4'd1;
                        end
                    end
                end
                IFS: begin
                    if (bus.bit_tick) begin
                        if (cnt == IFS_LAST) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                            done_nx  = 1'b1;
                            act_nx   = 1'b0;
                            psv_nx   = 1'b0;
                        end else begin
                            cnt_nx = cnt + 4'd1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.act_err_frm_tx = act;
    assign bus.psv_err_frm_tx = psv;
    assign bus.err_tx_bit     = ~((state == FLAG) && act);
    assign bus.err_code       = code;
    assign bus.err_evt        = evt;
    assign bus.err_frm_done   = done;

endmodule
